rom_stream_tx: RTL and testbench
================================

ROM_STREAM_TX -- requirements
Module: rom_stream_tx

Interface
REQ-001 Parameter WR_GAP, default 4: sys_clk cycles ioctl_wr stays low after each write pulse before the next pulse or any ioctl_wait sample; legal range 2..15.
REQ-002 Parameter MAX_REGIONS, default 16: number of descriptor slots; desc_idx width is 4.
REQ-003 sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 board_cfg  in  8  first byte of the stream; captured on accepted start.
REQ-007 num_regions  in  5  region count, 0..MAX_REGIONS; captured on accepted start.
REQ-008 desc_idx  out  4  descriptor slot being read.
REQ-009 desc_region  in  8  region index byte for slot desc_idx (combinational lookup).
REQ-010 desc_size  in  24  byte count for slot desc_idx.
REQ-011 desc_src  in  24  source byte address for slot desc_idx.
REQ-012 src_addr  out  24  source read address.
REQ-013 src_rd  out  1  one-cycle source read strobe.
REQ-014 src_valid  in  1  source data valid, any latency >= 1 cycle after src_rd.
REQ-015 src_data  in  8  source byte, qualified by src_valid.
REQ-016 ioctl_downl  out  1  download-active framing.
REQ-017 ioctl_wr  out  1  one-cycle byte write pulse.
REQ-018 ioctl_data  out  8  byte, stable from pulse cycle until next pulse.
REQ-019 ioctl_wait  in  1  receiver backpressure.
REQ-020 busy  out  1  high from accepted start until DONE exits.
REQ-021 done  out  1  one-cycle pulse at end of transfer.

Function
REQ-022 States SHALL be IDLE, CFG, DESC, IDX, SZ2, SZ1, SZ0, FETCH, EMIT, GAP, FINISH.
REQ-023 IDLE: start=1 -> capture board_cfg/num_regions, region counter=0, ioctl_downl=1, busy=1, go CFG; start while busy SHALL be ignored.
REQ-024 Every stream byte SHALL pass EMIT: ioctl_data set and ioctl_wr=1 for exactly one cycle, then GAP.
REQ-025 GAP: count WR_GAP cycles with ioctl_wr=0, then hold until ioctl_wait=0, then advance; ioctl_wait SHALL NOT be sampled before the count expires.
REQ-026 Byte order: board_cfg; per region k=0..num_regions-1: desc_region, desc_size[23:16], desc_size[15:8], desc_size[7:0], then desc_size data bytes.
REQ-027 DESC: desc_idx=k; latch desc_region, desc_size, desc_src in one cycle; byte counter=0.
REQ-028 After SZ0: size 0 -> next region (no data bytes); else FETCH.
REQ-029 FETCH: src_addr=src_base+counter (24-bit, wraps modulo 2^24), src_rd pulse one cycle, wait src_valid, latch src_data, go EMIT; src_valid outside FETCH SHALL be ignored.
REQ-030 Counter 24-bit; last data byte when counter==size-1; then k+1; k==num_regions -> FINISH.
REQ-031 num_regions=0: stream SHALL be board_cfg only.
REQ-032 num_regions>MAX_REGIONS SHALL be clamped to MAX_REGIONS.
REQ-033 FINISH: after final GAP completes, ioctl_downl=0, done=1 one cycle, busy=0, IDLE.
REQ-034 ioctl_downl SHALL stay high continuously from CFG through final GAP.
REQ-035 Total ioctl_wr pulses SHALL equal 1 + sum(4 + size_k).

Reset
REQ-036 reset SHALL force IDLE asynchronously; ioctl_downl, ioctl_wr, src_rd, busy, done = 0; ioctl_data, src_addr, desc_idx, counters = 0.
REQ-037 reset mid-transfer SHALL abort without completing the pulse in flight; no done pulse.

Verification
REQ-038 num_regions=0, board_cfg=0x5A, ioctl_wait=0 -> exactly one pulse with data 0x5A, then downl falls, done pulses once.
REQ-039 One region idx 0x03 size 3 src 0x000100 holding 11,22,33 -> bytes 03,00,00,03,11,22,33 after cfg; src_addr 0x100,0x101,0x102.
REQ-040 Region sizes {0,2} -> second header follows first SZ0 directly; 1+4+4+2=11 pulses total.
REQ-041 ioctl_wait held high 20 cycles after each pulse -> next pulse no earlier than wait fall; no pulses lost or duplicated; pulse spacing >= WR_GAP+1.
REQ-042 src_valid latency 1 vs 7 cycles -> identical byte sequence; spurious src_valid in GAP ignored.
REQ-043 reset asserted during data phase -> all outputs zero same cycle; later start yields full correct stream from board_cfg.

Source files
------------

// File: rtl/rom_stream_tx.sv
// rom_stream_tx: streams board_cfg, then per-region headers and source bytes, as paced ioctl write pulses.
module rom_stream_tx #(
  parameter int WR_GAP = 4,
  parameter int MAX_REGIONS = 16
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  board_cfg,
  input  logic [4:0]  num_regions,
  output logic [3:0]  desc_idx,
  input  logic [7:0]  desc_region,
  input  logic [23:0] desc_size,
  input  logic [23:0] desc_src,
  output logic [23:0] src_addr,
  output logic        src_rd,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        ioctl_downl,
  output logic        ioctl_wr,
  output logic [7:0]  ioctl_data,
  input  logic        ioctl_wait,
  output logic        busy,
  output logic        done
);
  typedef enum logic [3:0] {IDLE, CFG, DESC, IDX, SZ2, SZ1, SZ0, FETCH, EMIT, GAP, FINISH} state_t;
  state_t state, nxt, after_region;
  logic [7:0] cfg, region;
  logic [4:0] nreg, k, k_inc;
  logic [23:0] size, src, cnt;
  logic [3:0] gcnt;
  logic issued;
  assign k_inc = k + 5'd1;
  assign desc_idx = k[3:0];
  assign after_region = (k_inc == nreg) ? FINISH : DESC;
  // Byte states load ioctl_data and raise the pulse; EMIT/GAP then resume at nxt.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      nxt <= IDLE;
      cfg <= '0;
      region <= '0;
      nreg <= '0;
      k <= '0;
      size <= '0;
      src <= '0;
      cnt <= '0;
      gcnt <= '0;
      issued <= 1'b0;
      src_addr <= '0;
      src_rd <= 1'b0;
      ioctl_downl <= 1'b0;
      ioctl_wr <= 1'b0;
      ioctl_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      ioctl_wr <= 1'b0;
      src_rd <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cfg <= board_cfg;
          nreg <= (num_regions > 5'(MAX_REGIONS)) ? 5'(MAX_REGIONS) : num_regions;
          k <= '0;
          ioctl_downl <= 1'b1;
          busy <= 1'b1;
          state <= CFG;
        end
        CFG: begin
          ioctl_data <= cfg;
          ioctl_wr <= 1'b1;
          nxt <= (nreg == 5'd0) ? FINISH : DESC;
          state <= EMIT;
        end
        DESC: begin
          region <= desc_region;
          size <= desc_size;
          src <= desc_src;
          cnt <= '0;
          state <= IDX;
        end
        IDX: begin
          ioctl_data <= region;
          ioctl_wr <= 1'b1;
          nxt <= SZ2;
          state <= EMIT;
        end
        SZ2: begin
          ioctl_data <= size[23:16];
          ioctl_wr <= 1'b1;
          nxt <= SZ1;
          state <= EMIT;
        end
        SZ1: begin
          ioctl_data <= size[15:8];
          ioctl_wr <= 1'b1;
          nxt <= SZ0;
          state <= EMIT;
        end
        SZ0: begin
          ioctl_data <= size[7:0];
          ioctl_wr <= 1'b1;
          state <= EMIT;
          if (size == 24'd0) begin
            k <= k_inc;
            nxt <= after_region;
          end else nxt <= FETCH;
        end
        FETCH: if (!issued) begin
          src_addr <= src + cnt;
          src_rd <= 1'b1;
          issued <= 1'b1;
        end else if (src_valid) begin
          issued <= 1'b0;
          ioctl_data <= src_data;
          ioctl_wr <= 1'b1;
          state <= EMIT;
          if (cnt == size - 24'd1) begin
            k <= k_inc;
            nxt <= after_region;
          end else begin
            cnt <= cnt + 24'd1;
            nxt <= FETCH;
          end
        end
        EMIT: begin
          gcnt <= '0;
          state <= GAP;
        end
        GAP: if (gcnt != 4'(WR_GAP)) gcnt <= gcnt + 4'd1;
             else if (!ioctl_wait) state <= nxt;
        FINISH: begin
          ioctl_downl <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_stream_tx.sv
// tb_rom_stream_tx: randomized transfers checked against a queue-based model of the byte stream.
module tb_rom_stream_tx;
  localparam int WR_GAP = 4;
  localparam int MAXR = 16;
  logic sys_clk = 1'b0;
  logic reset, start;
  logic [7:0] board_cfg;
  logic [4:0] num_regions;
  logic [3:0] desc_idx;
  logic [7:0] desc_region;
  logic [23:0] desc_size, desc_src, src_addr;
  logic src_rd, src_valid;
  logic [7:0] src_data;
  logic ioctl_downl, ioctl_wr, ioctl_wait, busy, done;
  logic [7:0] ioctl_data;
  logic [7:0] d_region [MAXR];
  logic [23:0] d_size [MAXR];
  logic [23:0] d_src [MAXR];
  logic [7:0] rom_ovr [int];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  logic [23:0] addr_q [$];
  int checks = 0, errors = 0, cyc = 0, last_pulse = -1000, done_cnt = 0, lat = 0, wmode = 0, lmode = 1, flaws = 0;

  always #5 sys_clk = ~sys_clk;
  assign desc_region = d_region[desc_idx];
  assign desc_size = d_size[desc_idx];
  assign desc_src = d_src[desc_idx];

  rom_stream_tx #(.WR_GAP(WR_GAP), .MAX_REGIONS(MAXR)) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start), .board_cfg(board_cfg), .num_regions(num_regions),
    .desc_idx(desc_idx), .desc_region(desc_region), .desc_size(desc_size), .desc_src(desc_src),
    .src_addr(src_addr), .src_rd(src_rd), .src_valid(src_valid), .src_data(src_data),
    .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    return rom_ovr.exists(int'(a)) ? rom_ovr[int'(a)] : (a[7:0] ^ {a[15:12], a[19:16]} ^ 8'hA5);
  endfunction

  // Source memory: answers each read after lat cycles, and injects junk valids in gaps.
  initial begin
    logic [23:0] a;
    logic pw;
    src_valid = 1'b0;
    src_data = '0;
    a = '0;
    pw = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      src_valid = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          src_valid = 1'b1;
          src_data = rom_byte(a);
        end
      end else if (src_rd) begin
        a = src_addr;
        lat = (lmode == 0) ? int'($urandom_range(1, 7)) : lmode;
        if (addr_q.size() == 0) chk("src_addr_extra", 64'(src_addr), 64'hFFFF_FFFF);
        else chk("src_addr", 64'(src_addr), 64'(addr_q.pop_front()));
      end else if (pw && $urandom_range(0, 1) == 1) begin
        src_valid = 1'b1;
        src_data = 8'hEE;
      end
      pw = ioctl_wr;
    end
  end

  // Receiver: records pulses and drives backpressure.
  initial begin
    int hold;
    hold = 0;
    ioctl_wait = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      cyc++;
      if (done) done_cnt++;
      if (busy !== ioctl_downl) flaws++;
      if (ioctl_wr) begin
        got_q.push_back(ioctl_data);
        chk("spacing", 64'(cyc - last_pulse >= WR_GAP + 1), 64'd1);
        chk("downl_at_wr", 64'(ioctl_downl), 64'd1);
        if (wmode == 2) chk("wait_hold", 64'(cyc - last_pulse >= 20), 64'd1);
        last_pulse = cyc;
        if (wmode == 2) hold = 20;
      end
      ioctl_wait = (wmode == 1) ? ($urandom_range(0, 3) == 0) : (hold > 0);
      if (hold > 0) hold--;
    end
  end

  task automatic fill(input int maxsz);
    for (int k = 0; k < MAXR; k++) begin
      d_region[k] = 8'($urandom);
      d_size[k] = 24'($urandom_range(0, maxsz));
      d_src[k] = 24'($urandom);
    end
  endtask

  task automatic run(input string tag, input logic [7:0] cfg, input logic [4:0] n, input int wm, input int lm, input bit abort);
    int nn, budget;
    wmode = wm;
    lmode = lm;
    exp_q = {};
    got_q = {};
    addr_q = {};
    done_cnt = 0;
    flaws = 0;
    last_pulse = -1000;
    exp_q.push_back(cfg);
    nn = (int'(n) > MAXR) ? MAXR : int'(n);
    for (int k = 0; k < nn; k++) begin
      exp_q.push_back(d_region[k]);
      exp_q.push_back(d_size[k][23:16]);
      exp_q.push_back(d_size[k][15:8]);
      exp_q.push_back(d_size[k][7:0]);
      for (int i = 0; i < int'(d_size[k]); i++) begin
        addr_q.push_back(d_src[k] + 24'(i));
        exp_q.push_back(rom_byte(d_src[k] + 24'(i)));
      end
    end
    @(posedge sys_clk);
    #2;
    start = 1'b1;
    board_cfg = cfg;
    num_regions = n;
    @(posedge sys_clk);
    #2;
    start = 1'b0;
    board_cfg = ~cfg;
    num_regions = 5'd0;
    chk({tag, " busy"}, 64'(busy), 64'd1);
    repeat (2) @(posedge sys_clk);
    #2;
    start = 1'b1;
    @(posedge sys_clk);
    #2;
    start = 1'b0;
    budget = 0;
    while (done_cnt == 0 && budget < 20000 && !(abort && got_q.size() >= 7)) begin
      @(posedge sys_clk);
      #2;
      budget++;
    end
    if (abort) begin
      reset = 1'b1;
      #1;
      chk({tag, " rst_ctl"}, 64'({ioctl_downl, ioctl_wr, src_rd, busy, done}), 64'd0);
      chk({tag, " rst_data"}, 64'({ioctl_data, src_addr, desc_idx}), 64'd0);
      @(posedge sys_clk);
      #2;
      reset = 1'b0;
      lat = 0;
      repeat (30) @(posedge sys_clk);
      #2;
      chk({tag, " no_done"}, 64'(done_cnt), 64'd0);
      return;
    end
    chk({tag, " finished"}, 64'(done_cnt != 0), 64'd1);
    chk({tag, " busy_off"}, 64'({busy, ioctl_downl}), 64'd0);
    chk({tag, " pulses"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, " reads_left"}, 64'(addr_q.size()), 64'd0);
    repeat (4) @(posedge sys_clk);
    #2;
    chk({tag, " one_done"}, 64'(done_cnt), 64'd1);
    chk({tag, " downl_eq_busy"}, 64'(flaws), 64'd0);
  endtask

  initial begin
    logic [7:0] c;
    reset = 1'b1;
    start = 1'b0;
    board_cfg = '0;
    num_regions = '0;
    for (int k = 0; k < MAXR; k++) begin
      d_region[k] = '0;
      d_size[k] = '0;
      d_src[k] = '0;
    end
    repeat (3) @(posedge sys_clk);
    #2;
    chk("reset_ctl", 64'({ioctl_downl, ioctl_wr, src_rd, busy, done}), 64'd0);
    chk("reset_data", 64'({ioctl_data, src_addr, desc_idx}), 64'd0);
    reset = 1'b0;
    run("cfg_only", 8'h5A, 5'd0, 0, 1, 1'b0);
    chk("cfg_only count", 64'(got_q.size()), 64'd1);
    d_region[0] = 8'h03;
    d_size[0] = 24'd3;
    d_src[0] = 24'h000100;
    rom_ovr[256] = 8'h11;
    rom_ovr[257] = 8'h22;
    rom_ovr[258] = 8'h33;
    run("one_region", 8'hC3, 5'd1, 0, 1, 1'b0);
    d_size[0] = 24'd0;
    d_region[1] = 8'h44;
    d_size[1] = 24'd2;
    d_src[1] = 24'h000200;
    run("sizes_0_2", 8'h10, 5'd2, 0, 3, 1'b0);
    chk("sizes_0_2 count", 64'(got_q.size()), 64'd11);
    d_src[0] = 24'hFFFFFE;
    d_size[0] = 24'd4;
    run("wrap", 8'h77, 5'd1, 1, 0, 1'b0);
    fill(5);
    c = 8'($urandom);
    run("lat1", c, 5'd4, 0, 1, 1'b0);
    run("lat7", c, 5'd4, 0, 7, 1'b0);
    fill(4);
    run("wait20", 8'h96, 5'd3, 2, 0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      fill(5);
      run($sformatf("rand%0d", r), 8'($urandom), 5'($urandom_range(0, 16)), int'($urandom_range(0, 1)), 0, 1'b0);
    end
    fill(2);
    run("clamp", 8'h3C, 5'd20, 0, 1, 1'b0);
    fill(3);
    d_size[0] = 24'd6;
    run("abort", 8'hA1, 5'd2, 0, 2, 1'b1);
    run("after_abort", 8'hA1, 5'd2, 0, 2, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
